// File: rtl/psum_drain_accumulator_if.sv
// rtl/psum_drain_accumulator_if.sv - psum input, drained result stream and tile status bundle
interface psum_drain_accumulator_if #(
  parameter int PSUM_W = 10,
  parameter int OUT_W  = 8
);
  logic signed [PSUM_W-1:0] psum_i;
  logic                     psum_valid_i;
  logic                     clear_i;
  logic signed [OUT_W-1:0]  acc_o;
  logic                     acc_valid_o;
  logic                     acc_ready_i;
  logic                     busy_o;
  logic                     done_o;
  logic                     overflow_o;

  modport master (
    output psum_i, psum_valid_i, clear_i, acc_ready_i,
    input  acc_o, acc_valid_o, busy_o, done_o, overflow_o
  );

  modport slave (
    input  psum_i, psum_valid_i, clear_i, acc_ready_i,
    output acc_o, acc_valid_o, busy_o, done_o, overflow_o
  );
endinterface

// File: rtl/psum_drain_accumulator.sv
// rtl/psum_drain_accumulator.sv - accumulates PE partial sums per tile and drains rescaled results
// Optional: define PSUM_RELU_EN to clamp negative drained values to zero before saturation.
module psum_drain_accumulator #(
  parameter int PSUM_W = 10,
  parameter int ACC_W  = 16,
  parameter int DEPTH  = 8,
  parameter int PASSES = 3,
  parameter int SHIFT  = 2,
  parameter int OUT_W  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  psum_drain_accumulator_if.slave io
);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PCNT_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [PCNT_W-1:0] LAST_PASS = PCNT_W'(PASSES - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [PCNT_W-1:0]       pass_cnt_q, pass_cnt_d;
  logic signed [OUT_W-1:0] acc_q, acc_d;
  logic                    acc_valid_q, acc_valid_d;
  logic                    done_q, done_d;
  logic                    ovf_q, ovf_d;

  logic signed [ACC_W-1:0] buf_q [DEPTH];
  logic                    buf_we;
  logic signed [ACC_W-1:0] buf_wdata;
  logic signed [ACC_W-1:0] psum_ext, buf_rd, add_sum;
  logic [ACC_W:0]          sum_wide;
  logic                    add_ovf;

  function automatic logic signed [OUT_W-1:0] drain_conv(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> SHIFT;
`ifdef PSUM_RELU_EN
    if (s[ACC_W-1]) s = '0;
`endif
    if (s > OUT_MAX)      return OUT_MAX[OUT_W-1:0];
    else if (s < OUT_MIN) return OUT_MIN[OUT_W-1:0];
    else                  return s[OUT_W-1:0];
  endfunction

  assign psum_ext = {{(ACC_W-PSUM_W){io.psum_i[PSUM_W-1]}}, io.psum_i};
  assign buf_rd   = buf_q[wr_idx_q];
  assign sum_wide = {buf_rd[ACC_W-1], buf_rd} + {psum_ext[ACC_W-1], psum_ext};
  // Differing top two bits of the widened sum means the signed ACC_W range was exceeded.
  assign add_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
  assign add_sum  = add_ovf ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_W-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    pass_cnt_d  = pass_cnt_q;
    acc_d       = acc_q;
    acc_valid_d = acc_valid_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    buf_we      = 1'b0;
    buf_wdata   = (pass_cnt_q == '0) ? psum_ext : add_sum;

    if (io.clear_i) begin
      state_d     = IDLE;
      wr_idx_d    = '0;
      rd_idx_d    = '0;
      pass_cnt_d  = '0;
      acc_d       = '0;
      acc_valid_d = 1'b0;
      ovf_d       = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, ACCUM: begin
          if (io.psum_valid_i) begin
            buf_we  = 1'b1;
            state_d = ACCUM;
            if (pass_cnt_q != '0 && add_ovf) ovf_d = 1'b1;
            if (wr_idx_q == LAST_IDX) begin
              wr_idx_d = '0;
              if (pass_cnt_q == LAST_PASS) begin
                pass_cnt_d = '0;
                rd_idx_d   = '0;
                state_d    = DRAIN;
              end else begin
                pass_cnt_d = pass_cnt_q + 1'b1;
              end
            end else begin
              wr_idx_d = wr_idx_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (io.psum_valid_i) ovf_d = 1'b1;
          // The first entry is loaded one cycle after entry; later ones on each handshake.
          if (!acc_valid_q) begin
            acc_valid_d = 1'b1;
            acc_d       = drain_conv(buf_q[rd_idx_q]);
          end else if (io.acc_ready_i) begin
            if (rd_idx_q == LAST_IDX) begin
              acc_valid_d = 1'b0;
              done_d      = 1'b1;
              rd_idx_d    = '0;
              state_d     = IDLE;
            end else begin
              rd_idx_d = rd_idx_q + 1'b1;
              acc_d    = drain_conv(buf_q[rd_idx_q + 1'b1]);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      pass_cnt_q  <= '0;
      acc_q       <= '0;
      acc_valid_q <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      pass_cnt_q  <= pass_cnt_d;
      acc_q       <= acc_d;
      acc_valid_q <= acc_valid_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (buf_we) buf_q[wr_idx_q] <= buf_wdata;
  end

  assign io.acc_o       = acc_q;
  assign io.acc_valid_o = acc_valid_q;
  assign io.busy_o      = (state_q != IDLE);
  assign io.done_o      = done_q;
  assign io.overflow_o  = ovf_q;
endmodule
